// File: rtl/csidh_shadd_pipe.sv
// csidh_shadd_pipe: two-stage shift-add / reduced-radix carry-propagate unit with valid/ready handshake
module csidh_shadd_pipe #(
    parameter int XLEN  = 64,
    parameter int RADIX = 57,
    parameter int SHW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [SHW-1:0]  shamt,
    input  logic            op_srliadd,
    input  logic            op_sraiadd,
    input  logic            op_cprop,
    input  logic            op_cclr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic [XLEN-1:0] carry_out
);
    logic            op_ok;
    logic            fill;
    logic [XLEN-1:0] layer [SHW+1];
    logic            s1_valid;
    logic            s1_add;
    logic            s1_cprop;
    logic            s1_cclr;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_shift;
    logic            s1_advance;
    logic [XLEN-1:0] carry;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] carry_next;

    assign op_ok      = $onehot({op_cclr, op_cprop, op_sraiadd, op_srliadd});
    assign fill       = op_sraiadd & rs2[XLEN-1];
    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign carry_out  = carry;
    assign layer[0]   = rs2;

    for (genvar g = 0; g < SHW; g++) begin : g_shift
        assign layer[g+1] = shamt[g] ? {{(2**g){fill}}, layer[g][XLEN-1:2**g]} : layer[g];
    end

    // S2 datapath: cprop adds the live carry instead of the shifted operand; malformed ops yield 0
    always_comb begin
        sum        = s1_rs1 + (s1_cprop ? carry : s1_shift);
        result     = s1_cprop ? {{(XLEN-RADIX){1'b0}}, sum[RADIX-1:0]} : (s1_add ? sum : '0);
        carry_next = XLEN'($signed(sum) >>> RADIX);
    end

    // S1 register: capture operands and the pre-shifted rs2 on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_add   <= 1'b0;
            s1_cprop <= 1'b0;
            s1_cclr  <= 1'b0;
            s1_rs1   <= '0;
            s1_shift <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_add   <= op_ok & (op_srliadd | op_sraiadd);
            s1_cprop <= op_ok & op_cprop;
            s1_cclr  <= op_ok & op_cclr;
            s1_rs1   <= rs1;
            s1_shift <= layer[SHW];
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 register: result held while stalled, forced to 0 once drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd        <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            rd        <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            rd        <= '0;
        end
    end

    // Carry register: updated as a cprop/cclr enters S2 so the next cprop in S1 sees it immediately
    always_ff @(posedge clk) begin
        if (rst)
            carry <= '0;
        else if (s1_advance && s1_cprop)
            carry <= carry_next;
        else if (s1_advance && s1_cclr)
            carry <= '0;
    end
endmodule

// File: tb/tb_csidh_shadd_pipe.sv
// tb_csidh_shadd_pipe: directed self-checking bench for csidh_shadd_pipe
module tb_csidh_shadd_pipe;
    localparam logic [3:0] SRLI  = 4'b0001;
    localparam logic [3:0] SRAI  = 4'b0010;
    localparam logic [3:0] CPROP = 4'b0100;
    localparam logic [3:0] CCLR  = 4'b1000;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [5:0]  shamt;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] rd;
    logic [63:0] carry_out;
    int          errors = 0;
    int          checks = 0;

    csidh_shadd_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .shamt(shamt),
        .op_srliadd(op[0]), .op_sraiadd(op[1]), .op_cprop(op[2]), .op_cclr(op[3]),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [5:0] s);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        shamt    = s;
    endtask

    task automatic issue_one(input string tag, input logic [3:0] o, input logic [63:0] a,
                             input logic [63:0] b, input logic [5:0] s,
                             input logic [63:0] exp_rd, input logic [63:0] exp_carry);
        @(negedge clk);
        drive(o, a, b, s);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_carry"}, carry_out, exp_carry);
    endtask

    initial begin
        int  sent;
        int  got;
        bit  saw_low;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rs1 = '0; rs2 = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rd", rd, 64'd0);
        check("rst_carry", carry_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        issue_one("srli63", SRLI, 64'd1, MSB, 6'd63, 64'd2, 64'd0);
        issue_one("srai4", SRAI, 64'd0, MSB, 6'd4, 64'hF800_0000_0000_0000, 64'd0);
        issue_one("srli4", SRLI, 64'd0, MSB, 6'd4, 64'h0800_0000_0000_0000, 64'd0);
        issue_one("shamt0", SRLI, 64'd5, 64'd7, 6'd0, 64'd12, 64'd0);
        issue_one("srai63", SRAI, 64'd10, MSB, 6'd63, 64'd9, 64'd0);
        issue_one("noop", 4'b0000, 64'd77, 64'd3, 6'd0, 64'd0, 64'd0);
        issue_one("cclr0", CCLR, 64'd9, 64'd9, 6'd1, 64'd0, 64'd0);

        @(negedge clk);
        drive(CPROP, 64'h0200_0000_0000_0005, 64'd0, 6'd0);
        @(negedge clk);
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        drive(CPROP, 64'h01FF_FFFF_FFFF_FFFF, 64'd0, 6'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_a_valid", 64'(out_valid), 64'd1);
        check("b2b_a_rd", rd, 64'd5);
        check("b2b_a_carry", carry_out, 64'd1);
        @(negedge clk);
        check("b2b_b_valid", 64'(out_valid), 64'd1);
        check("b2b_b_rd", rd, 64'd0);
        check("b2b_b_carry", carry_out, 64'd1);

        issue_one("multi_op", SRLI | CPROP, 64'd40, 64'd4, 6'd1, 64'd0, 64'd1);
        issue_one("cclr1", CCLR, 64'd0, 64'd0, 6'd0, 64'd0, 64'd0);
        issue_one("cprop_neg", CPROP, '1, 64'd0, 6'd0, 64'h01FF_FFFF_FFFF_FFFF, '1);

        sent = 0; got = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c < 6);
            in_valid  = sent < 8;
            op        = SRLI;
            rs1       = 64'(sent * 100);
            rs2       = 64'(sent) << 8;
            shamt     = 6'd4;
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                check("stream_rd", rd, 64'(got * 116));
                got++;
            end else if (!out_valid) begin
                check("stream_idle_rd", rd, 64'd0);
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_got", 64'(got), 64'd8);
        check("stream_backpressure", 64'(saw_low), 64'd1);
        check("stream_no_extra", 64'(out_valid), 64'd0);
        check("stream_carry_kept", carry_out, '1);

        @(negedge clk);
        out_ready = 1'b0;
        drive(SRLI, 64'd1, 64'd2, 6'd0);
        @(negedge clk);
        drive(SRLI, 64'd3, 64'd4, 6'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'd1);
        check("inflight_stall_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_rd", rd, 64'd0);
        check("midrst_carry", carry_out, 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
